lfsr_stream_rx: RTL and testbench

//  Receive/decipher end of the 4-bit LFSR keystream link. Regenerates the transmitter's keystream

---
 rtl/lfsr_pkg.sv | 28 ++
 rtl/lfsr_ks_gen.sv | 43 ++++
 rtl/lfsr_stream_rx.sv | 119 +++++++++++
 tb/tb_lfsr_stream_rx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR keystream link (transmit and receive ends).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   LFSR_W        : keystream register width
//   seed_t        : shared key seed type
//   TAP_HI/TAP_LO : feedback taps of L
//   ST_*          : receive FSM state encodings, mirrored by rx_state_e
package lfsr_pkg;

    localparam int LFSR_W = 4;

    typedef logic [LFSR_W-1:0] seed_t;

    // Feedback is the XOR of the two end taps of L.
    localparam int TAP_HI = LFSR_W - 1;
    localparam int TAP_LO = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_REKEY = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        REKEY = ST_REKEY
    } rx_state_e;

endpackage

// File: rtl/lfsr_ks_gen.sv
// Keystream generator: L[3:0], delayed feedback M, output bit K. Same recurrence as the transmitter.
// Latency: o_k for the next bit is valid the cycle after i_adv; a load is visible the cycle after i_load.
// Backpressure: none; advances only when i_adv is high. i_load has priority over i_adv.
//   i_clk, i_reset : clock, async active-high reset (reset loads from i_seed)
//   i_seed         : seed loaded on reset or i_load
//   i_load         : reload L=seed, M=0, K=seed[0]
//   i_adv          : advance one keystream step
//   o_k            : current keystream bit
module lfsr_ks_gen
    import lfsr_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_reset,
    input  seed_t i_seed,
    input  logic  i_load,
    input  logic  i_adv,
    output logic  o_k
);

    seed_t r_l;
    logic  r_m;
    logic  r_k;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_l <= i_seed;
            r_m <= 1'b0;
            r_k <= i_seed[0];
        end else if (i_load) begin
            r_l <= i_seed;
            r_m <= 1'b0;
            r_k <= i_seed[0];
        end else if (i_adv) begin
            // Feedback goes through M first, so it enters L one step late.
            r_m <= r_l[TAP_HI] ^ r_l[TAP_LO];
            r_k <= r_l[0];
            r_l <= {r_m, r_l[LFSR_W-1:1]};
        end
    end

    assign o_k = r_k;

endmodule

// File: rtl/lfsr_stream_rx.sv
// Deciphers a serial ciphertext bit stream with the regenerated keystream and packs LSB-first words.
// Latency: the bit completing a word (or frame) accepted at edge t -> o_pt_valid high after edge t.
// Backpressure: o_ct_ready low while a word is stalled on i_pt_ready or during the 1-cycle REKEY.
//   i_clk, i_reset                 : clock, async active-high reset
//   i_seed, i_seed_load            : shared seed; sync reload + frame abort
//   i_ct_valid/i_ct_bit/i_ct_last  : ciphertext bit stream, o_ct_ready handshake
//   o_pt_valid/o_pt_data/o_pt_last/o_pt_count, i_pt_ready : plaintext word output
//   o_keystream                    : current keystream bit (monitor)
module lfsr_stream_rx
    import lfsr_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  seed_t                        i_seed,
    input  logic                         i_seed_load,
    input  logic                         i_ct_valid,
    input  logic                         i_ct_bit,
    input  logic                         i_ct_last,
    output logic                         o_ct_ready,
    output logic                         o_pt_valid,
    output logic [WORD_W-1:0]            o_pt_data,
    output logic                         o_pt_last,
    output logic [$clog2(WORD_W+1)-1:0]  o_pt_count,
    input  logic                         i_pt_ready,
    output logic                         o_keystream
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_shift;

    logic              w_k;
    logic              w_ct_ready;
    logic              w_accept;
    logic              w_pt_bit;
    logic              w_word_done;
    logic              w_gen_load;
    logic [WORD_W-1:0] w_word;

    // Ready deliberately ignores i_ct_* so the sender can never form a combinational loop.
    assign w_ct_ready  = (r_state != ST_REKEY) && (!o_pt_valid || i_pt_ready);
    assign o_ct_ready  = w_ct_ready;

    // A bit arriving with a seed reload is dropped: it belongs to the aborted frame.
    assign w_accept    = i_ct_valid && w_ct_ready && !i_seed_load;
    assign w_pt_bit    = i_ct_bit ^ w_k;
    assign w_word_done = w_accept && ((r_cnt == CNT_W'(WORD_W - 1)) || i_ct_last);
    assign w_gen_load  = i_seed_load || (r_state == ST_REKEY);

    lfsr_ks_gen u_ks_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_seed  (i_seed),
        .i_load  (w_gen_load),
        .i_adv   (w_accept),
        .o_k     (w_k)
    );

    assign o_keystream = w_k;

    // Shift register with the current bit merged in at slot r_cnt; bits above r_cnt stay 0
    // because the register is cleared at every word boundary.
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < WORD_W; i++) begin
            if (w_accept && (r_cnt == CNT_W'(i))) begin
                w_word[i] = w_pt_bit;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_seed_load) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (r_state == ST_REKEY) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            if (w_word_done) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shift <= w_word;
            end
            r_state <= i_ct_last ? ST_REKEY : ST_RUN;
        end
    end

    // Output register; a word can only complete when the register is empty or being drained,
    // so a refill on the same edge as a consume gives back-to-back words.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pt_valid <= 1'b0;
            o_pt_data  <= '0;
            o_pt_last  <= 1'b0;
            o_pt_count <= '0;
        end else if (w_word_done) begin
            o_pt_valid <= 1'b1;
            o_pt_data  <= w_word;
            o_pt_last  <= i_ct_last;
            o_pt_count <= r_cnt + CNT_W'(1);
        end else if (i_pt_ready) begin
            o_pt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_stream_rx.sv
// Scoreboard bench for lfsr_stream_rx: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: i_pt_ready toggled by the stimulus.
module tb_lfsr_stream_rx;
    import lfsr_pkg::*;

    localparam int WORD_W = 8;
    localparam int CNT_W  = $clog2(WORD_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    seed_t             seed = 4'h9;
    logic              seed_load = 1'b0;
    logic              ct_valid = 1'b0;
    logic              ct_bit = 1'b0;
    logic              ct_last = 1'b0;
    logic              ct_ready;
    logic              pt_valid;
    logic [WORD_W-1:0] pt_data;
    logic              pt_last;
    logic [CNT_W-1:0]  pt_count;
    logic              pt_ready = 1'b1;
    logic              ks;

    lfsr_stream_rx #(.WORD_W(WORD_W)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_seed      (seed),
        .i_seed_load (seed_load),
        .i_ct_valid  (ct_valid),
        .i_ct_bit    (ct_bit),
        .i_ct_last   (ct_last),
        .o_ct_ready  (ct_ready),
        .o_pt_valid  (pt_valid),
        .o_pt_data   (pt_data),
        .o_pt_last   (pt_last),
        .o_pt_count  (pt_count),
        .i_pt_ready  (pt_ready),
        .o_keystream (ks)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] data;
        int                count;
        logic              last;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keystream as a 5-bit history: the next K is L[0]; the new top of L is the feedback
    // computed one step earlier (held in m_fb).
    int   m_l, m_fb, m_k;
    int   m_bits;
    logic [WORD_W-1:0] m_word;
    bit   m_rekey;

    function automatic void model_load(input int s);
        m_l  = s;
        m_fb = 0;
        m_k  = s & 1;
    endfunction

    function automatic void model_step();
        int fb;
        fb   = ((m_l >> 3) & 1) ^ (m_l & 1);
        m_k  = m_l & 1;
        m_l  = (m_fb << 3) | (m_l >> 1);
        m_fb = fb;
    endfunction

    // Model runs at the falling edge, predicting what the following rising edge will do.
    always @(negedge clk) begin
        if (rst) begin
            model_load(int'(seed));
            m_bits  = 0;
            m_word  = '0;
            m_rekey = 0;
            exp_q.delete();
        end else begin
            chk("keystream", int'(ks), m_k);
            chk("ct_ready", int'(ct_ready), int'(!m_rekey && (!pt_valid || pt_ready)));
            if (seed_load) begin
                model_load(int'(seed));
                m_bits  = 0;
                m_word  = '0;
                m_rekey = 0;
            end else if (m_rekey) begin
                model_load(int'(seed));
                m_bits  = 0;
                m_word  = '0;
                m_rekey = 0;
            end else if (ct_valid && (!pt_valid || pt_ready)) begin
                word_t w;
                m_word[m_bits] = ct_bit ^ m_k[0];
                m_bits++;
                model_step();
                if (m_bits == WORD_W || ct_last) begin
                    w.data  = m_word;
                    w.count = m_bits;
                    w.last  = ct_last;
                    exp_q.push_back(w);
                    m_bits = 0;
                    m_word = '0;
                    if (ct_last) m_rekey = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit                held = 0;
    logic [WORD_W-1:0] held_data;
    logic              held_last;
    logic [CNT_W-1:0]  held_count;

    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            if (held) begin
                chk("stall_valid", int'(pt_valid), 1);
                chk("stall_data", int'({held_data, held_last, held_count}),
                    int'({pt_data, pt_last, pt_count}));
            end
            if (pt_valid && pt_ready) begin
                word_t w;
                w.data  = pt_data;
                w.count = int'(pt_count);
                w.last  = pt_last;
                got_q.push_back(w);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", pt_data);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("word_data", int'(pt_data), int'(e.data));
                    chk("word_count", int'(pt_count), e.count);
                    chk("word_last", int'(pt_last), int'(e.last));
                end
            end
            held       = pt_valid && !pt_ready;
            held_data  = pt_data;
            held_last  = pt_last;
            held_count = pt_count;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input seed_t s);
        @(posedge clk); #2;
        seed = s;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", int'(pt_valid), 0);
        chk("rst_data", int'(pt_data), 0);
        chk("rst_last", int'(pt_last), 0);
        chk("rst_count", int'(pt_count), 0);
        chk("rst_keystream", int'(ks), int'(s[0]));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete();
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the bit.
    task automatic send(input logic b, input logic last);
        int guard;
        guard = 0;
        ct_valid = 1'b1;
        ct_bit   = b;
        ct_last  = last;
        @(negedge clk);
        while (!ct_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready=%0b expected 1", ct_ready);
        end
        @(posedge clk); #1;
        ct_valid = 1'b0;
        ct_last  = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (got_q.size() < n) begin
            total++;
            bad++;
            $display("FAIL pop_timeout: got %0d words expected %0d", got_q.size(), n);
        end
    endtask

    task automatic chk_got(input string name, input int idx, input int d, input int c, input int l);
        if (got_q.size() > idx) begin
            chk({name, "_data"}, int'(got_q[idx].data), d);
            chk({name, "_count"}, got_q[idx].count, c);
            chk({name, "_last"}, int'(got_q[idx].last), l);
        end
    endtask

    initial begin
        logic [7:0] pat;

        // 1: eight zero bits with seed 9 -> raw keystream byte.
        do_reset(4'h9);
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        wait_pops(1);
        chk_got("t1", 0, 8'h13, 8, 0);

        // 2: short frame, REKEY gap, keystream restarts.
        do_reset(4'h9);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        chk("rekey_ready", int'(ct_ready), 0);
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        wait_pops(2);
        chk_got("t2a", 0, 8'h03, 3, 1);
        chk_got("t2b", 1, 8'h13, 8, 0);

        // 3: zero seed is a passthrough.
        do_reset(4'h0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
        wait_pops(1);
        chk_got("t3", 0, 8'hA5, 8, 0);

        // 4: consumer stall holds the word and blocks the channel.
        do_reset(4'h9);
        pt_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        ct_valid = 1'b1;
        ct_bit   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", int'(ct_ready), 0);
        end
        @(posedge clk); #1;
        pt_ready = 1'b1;
        @(posedge clk); #1;
        ct_valid = 1'b0;
        for (int i = 0; i < 7; i++) send(1'b0, 1'b0);
        wait_pops(2);
        chk_got("t4", 0, 8'h13, 8, 0);

        // 5: seed reload mid-frame drops the coincident bit and restarts the keystream.
        do_reset(4'h9);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        ct_valid  = 1'b1;
        ct_bit    = 1'b1;
        seed_load = 1'b1;
        @(posedge clk); #1;
        ct_valid  = 1'b0;
        seed_load = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        wait_pops(1);
        chk_got("t5", 0, 8'h13, 8, 0);

        // 6: async reset mid-word (checked inside do_reset between edges).
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        do_reset(4'h6);

        // 7: randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            ct_valid  = ($urandom_range(0, 3) != 0);
            ct_bit    = 1'($urandom_range(0, 1));
            ct_last   = ($urandom_range(0, 9) == 0);
            pt_ready  = ($urandom_range(0, 9) < 7);
            seed_load = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) seed = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        ct_valid  = 1'b0;
        ct_last   = 1'b0;
        seed_load = 1'b0;
        pt_ready  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
